eth_axis_frame_gen: RTL and testbench

Single-clock Ethernet test-frame source that drives the 8-bit AXI-stream transmit input of the 1G MAC/FIFO path from the user-logic side. Each start pulse emits one frame: destination MAC, source MAC, EtherType, then an incrementing-byte payload. The MAC adds preamble, padding and FCS, so this block never generates them. It serves bring-up and loopback testing, paired with a frame checker on the receive stream.

---
 rtl/eth_frame_gen_pkg.sv | 43 ++++
 rtl/eth_axis_frame_gen.sv | 196 +++++++++++++++++++
 tb/tb_eth_axis_frame_gen.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_frame_gen_pkg.sv
// Shared types and helpers for the Ethernet test-frame generator.
// No logic of its own; the header byte mux lives here as a pure function.
// Consumers import with eth_frame_gen_pkg::*.
package eth_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    localparam int ETH_HDR_LEN = 14;

    // Header byte idx (0..13) of dst MAC, src MAC, EtherType, MSB first
    function automatic logic [7:0] hdr_byte(
        input logic [3:0]  idx,
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [15:0] etype
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = dst[47:40];
            4'd1:    b = dst[39:32];
            4'd2:    b = dst[31:24];
            4'd3:    b = dst[23:16];
            4'd4:    b = dst[15:8];
            4'd5:    b = dst[7:0];
            4'd6:    b = src[47:40];
            4'd7:    b = src[39:32];
            4'd8:    b = src[31:24];
            4'd9:    b = src[23:16];
            4'd10:   b = src[15:8];
            4'd11:   b = src[7:0];
            4'd12:   b = etype[15:8];
            4'd13:   b = etype[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eth_axis_frame_gen.sv
// Ethernet test-frame source: dst/src/type header then incrementing payload on 8-bit AXI-stream.
// Latency: start sampled at edge N, first byte valid from N+1; 1 byte/cycle with tready high.
// Backpressure: tready low holds tdata/tlast/tuser stable with tvalid high; start ignored while busy.
module eth_axis_frame_gen #(
    parameter int MAX_PAYLOAD = 1500,
    parameter int LEN_WIDTH   = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [47:0]          cfg_dst_mac,
    input  logic [47:0]          cfg_src_mac,
    input  logic [15:0]          cfg_ethertype,
    input  logic [LEN_WIDTH-1:0] cfg_payload_len,
    input  logic [7:0]           cfg_seed,
    input  logic                 cfg_bad,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          frame_count
);
    import eth_frame_gen_pkg::*;

    localparam int IW = LEN_WIDTH + 1;
    typedef logic [IW-1:0] idx_t;

    state_t state_q, state_d;

    // Frame parameters captured at start so cfg_* may change mid-frame
    logic [47:0]          dst_q, dst_d;
    logic [47:0]          src_q, src_d;
    logic [15:0]          type_q, type_d;
    logic                 bad_q, bad_d;
    idx_t                 last_idx_q, last_idx_d;

    // Index of the byte currently presented, and the next payload value
    idx_t                 idx_q, idx_d;
    logic [7:0]           pay_q, pay_d;

    logic [7:0]           tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic                 tuser_q, tuser_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [31:0]          fcnt_q, fcnt_d;

    logic [LEN_WIDTH-1:0] len_c;
    logic                 hs;
    logic                 is_last;
    idx_t                 idx_nxt;

    assign hs      = tvalid_q & m_axis_tready;
    assign is_last = (idx_q == last_idx_q);
    assign idx_nxt = idx_q + idx_t'(1);

    // Clamp the requested payload length into 1..MAX_PAYLOAD
    always_comb begin
        len_c = cfg_payload_len;
        if (cfg_payload_len == '0) begin
            len_c = LEN_WIDTH'(1);
        end else if (cfg_payload_len > LEN_WIDTH'(MAX_PAYLOAD)) begin
            len_c = LEN_WIDTH'(MAX_PAYLOAD);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance only on handshakes at the header and frame boundaries
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_HDR;
            ST_HDR:  if (hs && idx_q == idx_t'(ETH_HDR_LEN - 1)) state_d = ST_PAY;
            ST_PAY:  if (hs && is_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: prepare the byte that follows each handshake
    always_comb begin
        dst_d      = dst_q;
        src_d      = src_q;
        type_d     = type_q;
        bad_d      = bad_q;
        last_idx_d = last_idx_q;
        idx_d      = idx_q;
        pay_d      = pay_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tuser_d    = tuser_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fcnt_d     = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dst_d      = cfg_dst_mac;
                    src_d      = cfg_src_mac;
                    type_d     = cfg_ethertype;
                    bad_d      = cfg_bad;
                    last_idx_d = idx_t'(len_c) + idx_t'(ETH_HDR_LEN - 1);
                    idx_d      = '0;
                    pay_d      = cfg_seed;
                    tdata_d    = cfg_dst_mac[47:40];
                    tvalid_d   = 1'b1;
                    tlast_d    = 1'b0;
                    tuser_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_HDR, ST_PAY: begin
                if (hs) begin
                    if (is_last) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tuser_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        fcnt_d   = fcnt_q + 32'd1;
                    end else begin
                        idx_d = idx_nxt;
                        if (idx_nxt < idx_t'(ETH_HDR_LEN)) begin
                            tdata_d = hdr_byte(idx_nxt[3:0], dst_q, src_q, type_q);
                        end else begin
                            tdata_d = pay_q;
                            pay_d   = pay_q + 8'd1;
                        end
                        tlast_d = (idx_nxt == last_idx_q);
                        tuser_d = (idx_nxt == last_idx_q) & bad_q;
                    end
                end
            end
            default: begin
                tvalid_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_q      <= '0;
            src_q      <= '0;
            type_q     <= '0;
            bad_q      <= 1'b0;
            last_idx_q <= '0;
            idx_q      <= '0;
            pay_q      <= '0;
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            dst_q      <= dst_d;
            src_q      <= src_d;
            type_q     <= type_d;
            bad_q      <= bad_d;
            last_idx_q <= last_idx_d;
            idx_q      <= idx_d;
            pay_q      <= pay_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_eth_axis_frame_gen.sv
module tb_eth_axis_frame_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [47:0] cfg_dst_mac;
    logic [47:0] cfg_src_mac;
    logic [15:0] cfg_ethertype;
    logic [10:0] cfg_payload_len;
    logic [7:0]  cfg_seed;
    logic        cfg_bad;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;
    logic        done;
    logic [31:0] frame_count;

    eth_axis_frame_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_dst_mac     (cfg_dst_mac),
        .cfg_src_mac     (cfg_src_mac),
        .cfg_ethertype   (cfg_ethertype),
        .cfg_payload_len (cfg_payload_len),
        .cfg_seed        (cfg_seed),
        .cfg_bad         (cfg_bad),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .busy            (busy),
        .done            (done),
        .frame_count     (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Scoreboard entries: {tlast, tuser, tdata}
    logic [9:0] sb[$];

    int          hs_cnt   = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    int          last_end_cyc = 0;
    int          last_gap = 0;
    bit          after_last = 0;
    bit          stalled_prev = 0;
    logic [10:0] stall_snap;
    bit          rand_rdy = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compare each handshaked byte against the scoreboard
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n) begin
            if (busy) check("no_tvalid_gap", m_axis_tvalid, 1'b1);
            if (stalled_prev)
                check("stall_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, stall_snap);
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    check("extra_byte", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("byte", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, e);
                end
                hs_cnt++;
                if (after_last) begin
                    last_gap   = cyc - last_end_cyc;
                    after_last = 0;
                end
                if (m_axis_tlast) begin
                    last_end_cyc = cyc;
                    after_last   = 1;
                end
            end
            stalled_prev = m_axis_tvalid && !m_axis_tready;
            stall_snap   = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
            if (done) done_cnt++;
        end else begin
            stalled_prev = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                              input int len, input logic [7:0] seed, input logic bad, output int nbytes);
        int n;
        logic [7:0] b;
        n = (len == 0) ? 1 : ((len > 1500) ? 1500 : len);
        for (int i = 0; i < 6; i++) sb.push_back({2'b00, dst[47-8*i -: 8]});
        for (int i = 0; i < 6; i++) sb.push_back({2'b00, src[47-8*i -: 8]});
        sb.push_back({2'b00, et[15:8]});
        sb.push_back({2'b00, et[7:0]});
        for (int k = 0; k < n; k++) begin
            b = seed + 8'(k);
            sb.push_back({(k == n - 1), (k == n - 1) & bad, b});
        end
        nbytes = 14 + n;
    endtask

    task automatic set_cfg(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                           input int len, input logic [7:0] seed, input logic bad);
        cfg_dst_mac     = dst;
        cfg_src_mac     = src;
        cfg_ethertype   = et;
        cfg_payload_len = 11'(len);
        cfg_seed        = seed;
        cfg_bad         = bad;
    endtask

    task automatic run_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                             input int len, input logic [7:0] seed, input logic bad, output int nbytes);
        push_frame(dst, src, et, len, seed, bad, nbytes);
        set_cfg(dst, src, et, len, seed, bad);
        start = 1'b1;
        step();
        start = 1'b0;
        check("first_byte", {busy, m_axis_tvalid, m_axis_tdata}, {2'b11, dst[47:40]});
    endtask

    task automatic wait_done(input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(tag, done, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int h0;
        int d0;
        int dn;

        rst_n = 1'b0;
        start = 1'b0;
        m_axis_tready = 1'b1;
        set_cfg(48'h0, 48'h0, 16'h0, 4, 8'h00, 1'b0);
        #23;
        check("reset_outputs",
              {m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, done, m_axis_tdata, frame_count}, 64'h0);
        rst_n = 1'b1;
        step();

        // Basic frame
        d0 = done_cnt;
        h0 = hs_cnt;
        run_frame(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h88B5, 4, 8'hA0, 1'b0, nb);
        wait_done(100, "basic_done");
        check("basic_count", frame_count, 32'd1);
        check("basic_idle", {m_axis_tvalid, busy}, 2'b00);
        check("basic_hs", hs_cnt - h0, 18);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("basic_done_pulses", done_cnt - d0, 1);
        step();

        // Backpressure
        rand_rdy = 1;
        h0 = hs_cnt;
        run_frame(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h88B5, 4, 8'hA0, 1'b0, nb);
        wait_done(400, "bp_done");
        check("bp_hs", hs_cnt - h0, nb);
        check("bp_count", frame_count, 32'd2);
        rand_rdy = 0;
        step();
        step();

        // Clamp low: len 0 -> one payload byte equal to seed
        h0 = hs_cnt;
        run_frame(48'hAABBCCDDEEFF, 48'h112233445566, 16'h0800, 0, 8'h5C, 1'b0, nb);
        wait_done(100, "len0_done");
        check("len0_hs", hs_cnt - h0, 15);
        step();

        // Clamp high with payload wrap
        h0 = hs_cnt;
        run_frame(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h86DD, 2000, 8'hFE, 1'b0, nb);
        wait_done(3000, "len2000_done");
        check("len2000_hs", hs_cnt - h0, 1514);
        check("len2000_count", frame_count, 32'd4);
        step();

        // Mid-frame start pulse and cfg changes are ignored
        h0 = hs_cnt;
        run_frame(48'h001122334455, 48'h66778899AABB, 16'h1234, 8, 8'h10, 1'b0, nb);
        repeat (4) step();
        set_cfg(48'hDEADBEEF0000, 48'hCAFECAFECAFE, 16'hFFFF, 30, 8'h77, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(100, "ign_done");
        repeat (20) step();
        check("ign_count", frame_count, 32'd5);
        check("ign_hs", hs_cnt - h0, 22);
        check("ign_idle", busy, 1'b0);

        // Bad flag only on tlast
        run_frame(48'h0A0A0A0A0A0A, 48'h0B0B0B0B0B0B, 16'h9000, 10, 8'h00, 1'b1, nb);
        wait_done(100, "bad_done");
        check("bad_count", frame_count, 32'd6);
        step();

        // Reset mid-frame at byte 7
        h0 = hs_cnt;
        set_cfg(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h88B5, 20, 8'h30, 1'b0);
        push_frame(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h88B5, 20, 8'h30, 1'b0, nb);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (hs_cnt - h0 >= 6) break;
        end
        check("reached_byte7", hs_cnt - h0, 6);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {m_axis_tvalid, busy, done, frame_count}, 35'h0);
        sb.delete();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_count", frame_count, 32'd0);

        // Back-to-back frames with start held high
        after_last = 0;
        last_gap   = 0;
        push_frame(48'h111111111111, 48'h222222222222, 16'h0806, 3, 8'hC0, 1'b0, nb);
        push_frame(48'h111111111111, 48'h222222222222, 16'h0806, 3, 8'hC0, 1'b0, nb);
        set_cfg(48'h111111111111, 48'h222222222222, 16'h0806, 3, 8'hC0, 1'b0);
        start = 1'b1;
        dn = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (dn == 2) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_done_pulses", dn, 2);
        check("b2b_gap", last_gap, 2);
        repeat (10) step();
        check("b2b_count", frame_count, 32'd2);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
